buffer_serial_loader: RTL and testbench
=======================================

// Module: buffer_serial_loader
// PURPOSE
//  Upstream write sequencer for the memory buffer's serial (mode 0) write port. Accepts a
//  valid/ready word stream from the host/DMA side and scatters it into the N_BUF banks:
//  consecutive addresses within one bank, then on to the next bank. Drives one-hot
//  m0_w_en, m0_w_addr and m0_w_data. Raises done/error status for the control FSM.
// PARAMETERS
//  N_BUF        8   number of memory banks; one-hot write-enable width
//  ADDR_RAM     10  bank address width
//  WID_PE_BITS  16  data word width
// PORTS
//  clk               in   1              single clock; all logic on rising edge
//  rst               in   1              synchronous, active-high reset
//  cfg_start         in   1              start pulse; sampled only in IDLE
//  cfg_bank          in   $clog2(N_BUF)  first bank to fill
//  cfg_base_addr     in   ADDR_RAM       start address inside every bank
//  cfg_words_per_bank in  ADDR_RAM+1     words written per bank (1..2^ADDR_RAM)
//  cfg_num_banks     in   $clog2(N_BUF)+1 banks to fill (1..N_BUF)
//  abort             in   1              cancel the current load
//  s_valid           in   1              stream word valid
//  s_ready           out  1              loader accepts word this cycle
//  s_data            in   WID_PE_BITS    stream word
//  m0_w_en           out  N_BUF          one-hot bank write enable (registered)
//  m0_w_addr         out  ADDR_RAM       bank write address (registered)
//  m0_w_data         out  WID_PE_BITS    bank write data (registered)
//  busy              out  1              high in LOAD
//  done              out  1              one-cycle pulse at end of load or abort
//  error             out  1              sticky: bad config; cleared by next accepted cfg_start
// BEHAVIOUR
//  Reset: state=IDLE; m0_w_en=0, m0_w_addr=0, m0_w_data=0, s_ready=0, busy=0, done=0, error=0.
//  States: IDLE -> LOAD on cfg_start with legal config; IDLE -> DONE on cfg_start with
//   cfg_words_per_bank==0, cfg_words_per_bank>2^ADDR_RAM, cfg_num_banks==0 or >N_BUF
//   (sets error, no write issued). LOAD -> DONE when last word is accepted, or on abort.
//   DONE -> IDLE after exactly one cycle (done=1 in DONE only).
//  cfg_start latches all cfg_* into internal registers; cfg_* ignored outside IDLE.
//  s_ready = (state==LOAD) & ~abort (combinational). Accept = s_valid & s_ready.
//  Accept at edge t -> at t+1: m0_w_en=onehot(cur_bank), m0_w_addr=cur_addr, m0_w_data=s_data.
//   Latency 1 cycle; no accept -> m0_w_en=0 next cycle (addr/data hold last value).
//  Sequencing: cur_addr starts at cfg_base_addr, +1 per accept, wraps mod 2^ADDR_RAM.
//   After cfg_words_per_bank accepts in a bank: cur_addr<=cfg_base_addr,
//   cur_bank<=(cur_bank+1) mod N_BUF (wrap past N_BUF-1 to 0).
//  Total words = cfg_words_per_bank*cfg_num_banks; word counter width ADDR_RAM+$clog2(N_BUF)+1.
//  Last accept: transition to DONE; its write still issues on the following cycle.
//  Abort in LOAD: no accept that cycle, -> DONE; a write already registered still completes;
//   error unaffected. Abort in IDLE/DONE ignored.
//  cfg_start in LOAD/DONE ignored. Never more than one m0_w_en bit high.
//  rst mid-load: all state/outputs to reset values on that edge; pending write dropped.
// TESTING
//  1. Reset, start bank=0 base=0 wpb=4 nb=2, data 1..8 continuous -> writes bank0 addr0..3
//     =1..4, bank1 addr0..3=5..8; done pulse cycle after 8th accept; m0_w_en one-hot 8'h01/8'h02.
//  2. bank=7 base=1022 wpb=3 nb=2 (ADDR_RAM=10) -> bank7 addr1022,1023,0 then bank0
//     addr1022,1023,0 (addr and bank wrap).
//  3. s_valid toggled 1010.. with wpb=2 nb=1 -> m0_w_en high only one cycle after each
//     accept; addr 0 then 1; same final memory content as continuous stream.
//  4. Abort after 3 of 8 words -> exactly 3 writes, s_ready low in abort cycle, done pulse,
//     error=0; next cfg_start runs a fresh load from cfg_bank/base.
//  5. cfg_start with wpb=0 -> no writes, done pulse next cycle, error=1 sticky until next
//     legal start clears it.
//  6. rst asserted during LOAD with s_valid=1 -> next cycle all outputs 0, state IDLE;
//     cfg_start ignored while in LOAD.

Source files
------------

// File: rtl/buffer_serial_loader.sv
// Serial (mode 0) write sequencer: scatters a valid/ready word stream across the
// buffer banks, filling consecutive addresses in one bank before moving to the next.
module buffer_serial_loader #(
  parameter int N_BUF       = 8,
  parameter int ADDR_RAM    = 10,
  parameter int WID_PE_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [$clog2(N_BUF)-1:0]   cfg_bank,
  input  logic [ADDR_RAM-1:0]        cfg_base_addr,
  input  logic [ADDR_RAM:0]          cfg_words_per_bank,
  input  logic [$clog2(N_BUF):0]     cfg_num_banks,
  input  logic                       abort,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WID_PE_BITS-1:0]     s_data,
  output logic [N_BUF-1:0]           m0_w_en,
  output logic [ADDR_RAM-1:0]        m0_w_addr,
  output logic [WID_PE_BITS-1:0]     m0_w_data,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  // state | meaning
  // IDLE  | waiting for cfg_start; cfg_* sampled here only
  // LOAD  | accepting stream words and issuing bank writes
  // DONE  | one-cycle done pulse after completion, abort or bad config

  localparam int BANK_W = $clog2(N_BUF);
  localparam int NB_W   = BANK_W + 1;
  localparam int WPB_W  = ADDR_RAM + 1;
  localparam int CNT_W  = ADDR_RAM + BANK_W + 1;

  localparam logic [WPB_W-1:0]  WPB_MAX  = {1'b1, {ADDR_RAM{1'b0}}};
  localparam logic [NB_W-1:0]   NB_MAX   = NB_W'(N_BUF);
  localparam logic [BANK_W-1:0] BANK_TOP = BANK_W'(N_BUF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BANK_W-1:0]      r_bank;
  logic [ADDR_RAM-1:0]    r_addr;
  logic [ADDR_RAM-1:0]    r_base;
  logic [WPB_W-1:0]       r_wpb;
  logic [WPB_W-1:0]       r_bank_left;
  logic [CNT_W-1:0]       r_words_left;
  logic [N_BUF-1:0]       r_w_en;
  logic [ADDR_RAM-1:0]    r_w_addr;
  logic [WID_PE_BITS-1:0] r_w_data;
  logic                   r_error;

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_start;
  logic                   w_cfg_bad;
  logic                   w_last;
  logic                   w_bank_end;
  logic [CNT_W-1:0]       w_total;
  logic [BANK_W-1:0]      w_bank_inc;
  logic [N_BUF-1:0]       w_onehot;
  logic                   w_busy;
  logic                   w_done;

  assign w_ready    = (r_state == S_LOAD) && !abort;
  assign w_accept   = s_valid && w_ready;
  assign w_start    = (r_state == S_IDLE) && cfg_start;
  assign w_cfg_bad  = (cfg_words_per_bank == '0) || (cfg_words_per_bank > WPB_MAX) ||
                      (cfg_num_banks == '0) || (cfg_num_banks > NB_MAX);
  assign w_last     = w_accept && (r_words_left == CNT_W'(1));
  assign w_bank_end = (r_bank_left == WPB_W'(1));
  // Legal configs keep the product within CNT_W bits (2^ADDR_RAM * N_BUF max).
  assign w_total    = CNT_W'(cfg_words_per_bank) * CNT_W'(cfg_num_banks);
  assign w_bank_inc = (r_bank == BANK_TOP) ? '0 : r_bank + 1'b1;
  assign w_onehot   = N_BUF'(1) << r_bank;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_state_nxt = w_cfg_bad ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        w_busy = 1'b1;
        if (abort || w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank       <= '0;
      r_addr       <= '0;
      r_base       <= '0;
      r_wpb        <= '0;
      r_bank_left  <= '0;
      r_words_left <= '0;
      r_w_en       <= '0;
      r_w_addr     <= '0;
      r_w_data     <= '0;
      r_error      <= 1'b0;
    end else begin
      r_w_en <= '0;
      if (w_start) begin
        r_error <= w_cfg_bad;
        if (!w_cfg_bad) begin
          r_base       <= cfg_base_addr;
          r_addr       <= cfg_base_addr;
          r_bank       <= cfg_bank;
          r_wpb        <= cfg_words_per_bank;
          r_bank_left  <= cfg_words_per_bank;
          r_words_left <= w_total;
        end
      end
      if (w_accept) begin
        r_w_en       <= w_onehot;
        r_w_addr     <= r_addr;
        r_w_data     <= s_data;
        r_words_left <= r_words_left - 1'b1;
        if (w_bank_end) begin
          r_bank_left <= r_wpb;
          r_addr      <= r_base;
          r_bank      <= w_bank_inc;
        end else begin
          r_bank_left <= r_bank_left - 1'b1;
          r_addr      <= r_addr + 1'b1;
        end
      end
    end
  end

  assign s_ready   = w_ready;
  assign m0_w_en   = r_w_en;
  assign m0_w_addr = r_w_addr;
  assign m0_w_data = r_w_data;
  assign busy      = w_busy;
  assign done      = w_done;
  assign error     = r_error;

endmodule

// File: tb/tb_buffer_serial_loader.sv
// Bench for buffer_serial_loader: per-cycle compare against a write-plan model plus
// hand-computed literal checks of the captured write log.
module tb_buffer_serial_loader;

  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic [2:0]  cfg_bank;
  logic [9:0]  cfg_base_addr;
  logic [10:0] cfg_words_per_bank;
  logic [3:0]  cfg_num_banks;
  logic        abort;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic [7:0]  m0_w_en;
  logic [9:0]  m0_w_addr;
  logic [15:0] m0_w_data;
  logic        busy;
  logic        done;
  logic        error;

  buffer_serial_loader #(.N_BUF(8), .ADDR_RAM(10), .WID_PE_BITS(16)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_bank(cfg_bank),
    .cfg_base_addr(cfg_base_addr), .cfg_words_per_bank(cfg_words_per_bank),
    .cfg_num_banks(cfg_num_banks), .abort(abort), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .m0_w_en(m0_w_en), .m0_w_addr(m0_w_addr),
    .m0_w_data(m0_w_data), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 loading, 2 done pulse; the write plan is the full ordered list
  // of (bank, addr) targets expanded when a legal start is seen.
  int         m_phase;
  logic [7:0] m_en;
  logic [9:0] m_addr;
  logic [15:0] m_data;
  logic       m_err;
  int         m_pb[$];
  int         m_pa[$];

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_en = '0; m_addr = '0; m_data = '0; m_err = 1'b0;
      m_pb.delete(); m_pa.delete();
    end else begin
      m_en = '0;
      case (m_phase)
        0: if (cfg_start) begin
          int wpb, nb;
          wpb = int'(cfg_words_per_bank);
          nb  = int'(cfg_num_banks);
          m_err = (wpb == 0) || (wpb > 1024) || (nb == 0) || (nb > 8);
          if (m_err) m_phase = 2;
          else begin
            m_pb.delete(); m_pa.delete();
            for (int b = 0; b < nb; b++)
              for (int w = 0; w < wpb; w++) begin
                m_pb.push_back((int'(cfg_bank) + b) % 8);
                m_pa.push_back((int'(cfg_base_addr) + w) % 1024);
              end
            m_phase = 1;
          end
        end
        1: begin
          if (abort) begin
            m_phase = 2; m_pb.delete(); m_pa.delete();
          end else if (s_valid) begin
            m_en   = 8'(1 << m_pb.pop_front());
            m_addr = 10'(m_pa.pop_front());
            m_data = s_data;
            if (m_pb.size() == 0) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  int lg_bank[$];
  int lg_addr[$];
  int lg_data[$];

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("s_ready", 32'(s_ready), 32'((m_phase == 1) && !abort));
      chk("m0_w_en", 32'(m0_w_en), 32'(m_en));
      chk("m0_w_addr", 32'(m0_w_addr), 32'(m_addr));
      chk("m0_w_data", 32'(m0_w_data), 32'(m_data));
      chk("busy", 32'(busy), 32'(m_phase == 1));
      chk("done", 32'(done), 32'(m_phase == 2));
      chk("error", 32'(error), 32'(m_err));
      chk("onehot", 32'($countones(m0_w_en) <= 1), 32'd1);
      if (m0_w_en != '0) begin
        for (int i = 0; i < 8; i++)
          if (m0_w_en[i]) lg_bank.push_back(i);
        lg_addr.push_back(int'(m0_w_addr));
        lg_data.push_back(int'(m0_w_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_log();
    lg_bank.delete(); lg_addr.delete(); lg_data.delete();
  endtask

  task automatic chk_log(input int idx, input int b, input int a, input int d);
    checks++;
    if (idx >= lg_bank.size()) begin
      errors++;
      $display("FAIL log[%0d] missing, log size=%0d expected entry bank=%0d addr=%0d data=%0h",
               idx, lg_bank.size(), b, a, d);
    end else if (lg_bank[idx] != b || lg_addr[idx] != a || lg_data[idx] != d) begin
      errors++;
      $display("FAIL log[%0d] got bank=%0d addr=%0d data=%0h expected bank=%0d addr=%0d data=%0h",
               idx, lg_bank[idx], lg_addr[idx], lg_data[idx], b, a, d);
    end
  endtask

  task automatic start_cfg(input int b, input int ba, input int w, input int n);
    cfg_bank = 3'(b); cfg_base_addr = 10'(ba);
    cfg_words_per_bank = 11'(w); cfg_num_banks = 4'(n);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send(input int v);
    s_valid = 1'b1;
    s_data  = 16'(v);
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_bank = '0; cfg_base_addr = '0;
    cfg_words_per_bank = '0; cfg_num_banks = '0; abort = 1'b0;
    s_valid = 1'b0; s_data = '0;
    tick();
    cmp_on = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_en", 32'(m0_w_en), 32'd0);
    chk("reset_busy_done_err", {29'd0, busy, done, error}, 32'd0);

    // 1: two banks of four, continuous stream
    clr_log();
    start_cfg(0, 0, 4, 2);
    for (int i = 1; i <= 8; i++) send(i);
    chk("t1_done_pulse", 32'(done), 32'd1);
    chk("t1_last_en", 32'(m0_w_en), 32'h02);
    s_valid = 1'b0;
    tick();
    chk("t1_done_clear", 32'(done), 32'd0);
    chk("t1_log_size", 32'(lg_bank.size()), 32'd8);
    chk_log(0, 0, 0, 1); chk_log(3, 0, 3, 4);
    chk_log(4, 1, 0, 5); chk_log(7, 1, 3, 8);

    // 2: address and bank wrap
    clr_log();
    start_cfg(7, 1022, 3, 2);
    for (int i = 0; i < 6; i++) send(16'h100 + i);
    s_valid = 1'b0;
    tick();
    chk_log(0, 7, 1022, 16'h100); chk_log(1, 7, 1023, 16'h101);
    chk_log(2, 7, 0, 16'h102);    chk_log(3, 0, 1022, 16'h103);
    chk_log(4, 0, 1023, 16'h104); chk_log(5, 0, 0, 16'h105);

    // 3: gapped stream
    clr_log();
    start_cfg(0, 0, 2, 1);
    send(16'hA);
    chk("t3_en_after_a", 32'(m0_w_en), 32'h01);
    s_valid = 1'b0;
    tick();
    chk("t3_en_gap", 32'(m0_w_en), 32'h00);
    chk("t3_data_hold", 32'(m0_w_data), 32'hA);
    send(16'hB);
    s_valid = 1'b0;
    tick();
    chk("t3_log_size", 32'(lg_bank.size()), 32'd2);
    chk_log(0, 0, 0, 16'hA); chk_log(1, 0, 1, 16'hB);

    // 4: abort after three words, then a fresh load
    clr_log();
    start_cfg(2, 5, 4, 2);
    send(16'h21); send(16'h22); send(16'h23);
    abort = 1'b1; s_valid = 1'b1; s_data = 16'h24;
    #1;
    chk("t4_ready_abort", 32'(s_ready), 32'd0);
    tick();
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_error", 32'(error), 32'd0);
    abort = 1'b0; s_valid = 1'b0;
    tick();
    chk("t4_log_size", 32'(lg_bank.size()), 32'd3);
    chk_log(0, 2, 5, 16'h21); chk_log(2, 2, 7, 16'h23);
    clr_log();
    start_cfg(2, 5, 1, 1);
    send(16'h30);
    s_valid = 1'b0;
    tick();
    chk_log(0, 2, 5, 16'h30);

    // 5: illegal configs set sticky error; legal start clears it
    clr_log();
    start_cfg(0, 0, 0, 1);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_error", 32'(error), 32'd1);
    tick(); tick(); tick();
    chk("t5_error_sticky", 32'(error), 32'd1);
    chk("t5_no_writes", 32'(lg_bank.size()), 32'd0);
    start_cfg(3, 0, 1, 1);
    chk("t5_error_cleared", 32'(error), 32'd0);
    send(16'h50);
    s_valid = 1'b0;
    tick();
    chk_log(0, 3, 0, 16'h50);
    start_cfg(0, 0, 4, 9);
    chk("t5_nb9_error", 32'(error), 32'd1);
    tick();
    start_cfg(0, 0, 1025, 1);
    chk("t5_wpb1025_error", 32'(error), 32'd1);
    tick();

    // 6: cfg_start ignored in LOAD, reset mid-load
    clr_log();
    start_cfg(4, 10, 4, 1);
    send(16'h61); send(16'h62);
    cfg_bank = 3'd1; cfg_base_addr = 10'd0; cfg_words_per_bank = 11'd1;
    cfg_num_banks = 4'd1; cfg_start = 1'b1;
    send(16'h63);
    cfg_start = 1'b0;
    chk("t6_still_busy", 32'(busy), 32'd1);
    chk("t6_en", 32'(m0_w_en), 32'h10);
    chk("t6_addr", 32'(m0_w_addr), 32'd12);
    rst = 1'b1; s_valid = 1'b1; s_data = 16'h64;
    tick();
    rst = 1'b0; s_valid = 1'b0;
    chk("t6_rst_outs", {8'd0, m0_w_en, 6'd0, m0_w_addr}, 32'd0);
    chk("t6_rst_data", 32'(m0_w_data), 32'd0);
    chk("t6_rst_flags", {28'd0, s_ready, busy, done, error}, 32'd0);
    chk("t6_log_size", 32'(lg_bank.size()), 32'd3);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
